automata_stepper: RTL and testbench

AUTOMATA_STEPPER -- requirements
Module: automata_stepper

---
 rtl/stepper_pkg.sv | 28 ++
 rtl/stepper_fifo.sv | 59 +++++
 rtl/automata_stepper.sv | 116 +++++++++++
 tb/tb_automata_stepper.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the automaton stepper: controller state encoding,
// datapath widths, the default vector FIFO depth and the result packing.
package stepper_pkg;

  localparam int DATA_W        = 8;
  localparam int AU_STATE_W    = 3;
  localparam int RES_W         = 11;
  localparam int COUNT_W       = 5;
  localparam int DEFAULT_DEPTH = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARST     = 3'd1,
    ST_FETCH    = 3'd2,
    ST_APPLY    = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Result word layout: automaton state in the upper bits, Mealy output below.
  function automatic logic [RES_W-1:0] pack_result(input logic [AU_STATE_W-1:0] s,
                                                   input logic [DATA_W-1:0]     c);
    return {s, c};
  endfunction

endpackage

// File: rtl/stepper_fifo.sv
// Synchronous FIFO holding the queued U vectors. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
// A write offered while full is dropped and latches a sticky overflow flag.
// DEPTH must be a power of 2 in the range 2..16.
module stepper_fifo
  import stepper_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         do_push;
  logic         do_pop;

  // Full when the indices match but the wrap bits differ.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_ready = !full && !rst;
    do_push  = wr_valid && wr_ready;
    do_pop   = pop && !empty;
    rd_data  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update and sticky overflow; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_valid && full) ovf <= 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/automata_stepper.sv
// Drives an external automaton from a queue of U vectors: resets it, then
// applies one vector per step and presents each {state, C} result for
// readout. Free-run mode steps continuously; single-step mode waits for a
// step pulse per vector.
//
// Handshakes: a transfer happens on the rising edge where valid and ready
// are both 1. valid, once raised, holds with its data stable until that
// edge; ready may be asserted independently of valid.
module automata_stepper
  import stepper_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  single,
  input  logic                  step,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  au_rst,
  output logic                  au_en,
  output logic [DATA_W-1:0]     au_u,
  input  logic [DATA_W-1:0]     au_c,
  input  logic [AU_STATE_W-1:0] au_state,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [RES_W-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    count,
  output logic                  err_ovf,
  output logic [2:0]            dbg_state
);

  state_t              state;
  state_t              state_nxt;
  logic                pop;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic [RES_W-1:0]    result;

  stepper_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .pop      (pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .ovf      (err_ovf)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the FIFO pop is issued from FETCH on the transition.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_ARST;
      ST_ARST:     state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (fifo_empty) begin
          state_nxt = ST_DONE;
        end else if (!single || step) begin
          pop       = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY:    state_nxt = ST_WAIT_OUT;
      ST_WAIT_OUT: if (rd_ready) state_nxt = ST_FETCH;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: au_u loads only on a pop, result captures during APPLY,
  // count clears in ARST and saturates on each accepted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      au_u   <= '0;
      result <= '0;
      count  <= '0;
    end else begin
      if (pop) au_u <= fifo_head;
      if (state == ST_APPLY) result <= pack_result(au_state, au_c);
      if (state == ST_ARST) begin
        count <= '0;
      end else if (state == ST_WAIT_OUT && rd_ready && count != COUNT_MAX) begin
        count <= count + 5'd1;
      end
    end
  end

  // Moore outputs, forced low while reset is held.
  always_comb begin
    au_rst    = (state == ST_ARST)     && !rst;
    au_en     = (state == ST_APPLY)    && !rst;
    rd_valid  = (state == ST_WAIT_OUT) && !rst;
    done      = (state == ST_DONE)     && !rst;
    busy      = (state != ST_IDLE)     && !rst;
    rd_data   = result;
    dbg_state = state;
  end

endmodule

// File: tb/tb_automata_stepper.sv
// Bench for automata_stepper: a small Mealy automaton model answers au_en /
// au_rst, directed scenarios drive the controller, and a negedge monitor
// compares every accepted result against the expected queue.
module tb_automata_stepper;
  import stepper_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        single;
  logic        step;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        au_rst;
  logic        au_en;
  logic [7:0]  au_u;
  logic [7:0]  au_c;
  logic [2:0]  au_state;
  logic        rd_valid;
  logic        rd_ready;
  logic [10:0] rd_data;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic        err_ovf;
  logic [2:0]  dbg_state;

  logic [10:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int sb_pass = 0;
  int sb_total = 0;
  int res_cnt = 0;
  int en_seen;
  int done_seen;

  // clock
  always #5 clk = ~clk;

  automata_stepper #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .single(single), .step(step),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .au_rst(au_rst), .au_en(au_en), .au_u(au_u), .au_c(au_c),
    .au_state(au_state), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy), .done(done), .count(count),
    .err_ovf(err_ovf), .dbg_state(dbg_state)
  );

  // Automaton model: N0 with U=0x00 gives C=0x91 and moves to N5;
  // N5 with U=0x02 gives C=0x7F.
  function automatic logic [7:0] au_out(input logic [2:0] s, input logic [7:0] u);
    if (s == 3'd0 && u == 8'h00) return 8'h91;
    if (s == 3'd5 && u == 8'h02) return 8'h7F;
    return u ^ {s, 5'h00} ^ 8'h5A;
  endfunction

  function automatic logic [2:0] au_next(input logic [2:0] s, input logic [7:0] u);
    if (s == 3'd0 && u == 8'h00) return 3'd5;
    return s + u[2:0] + 3'd1;
  endfunction

  logic [2:0] au_st;
  always_ff @(posedge clk) begin
    if (rst || au_rst) au_st <= 3'd0;
    else if (au_en)    au_st <= au_next(au_st, au_u);
  end
  assign au_state = au_st;
  assign au_c     = au_out(au_st, au_u);

  // scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      sb_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_data: unexpected result %03h, nothing expected", rd_data);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if (rd_data === e) sb_pass++;
        else $display("FAIL rd_data: got %03h expected %03h", rd_data, e);
      end
      res_cnt++;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    next_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    next_cycle();
    step = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_seen   += int'(au_en);
      done_seen += int'(done);
      next_cycle();
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      en_seen   += int'(au_en);
      done_seen += int'(done);
      if (done) found = 1'b1;
      next_cycle();
      if (found) break;
    end
  endtask

  task automatic wait_rd_valid(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rd_valid) found = 1'b1;
      next_cycle();
      if (found) break;
    end
  endtask

  initial begin
    bit          found;
    int          r0;
    logic [2:0]  ms;
    logic [7:0]  words [8];

    rst = 1'b1; start = 1'b0; single = 1'b0; step = 1'b0;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_au_en", au_en, 0);
    check("rst_au_rst", au_rst, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_count", count, 0);
    check("post_rst_err_ovf", err_ovf, 0);
    check("post_rst_au_u", au_u, 0);
    check("post_rst_rd_data", rd_data, 0);
    check("post_rst_wr_ready", wr_ready, 1);
    next_cycle();

    // single vector, free-run: au_rst pulse, au_en third cycle after start
    push_word(8'h00);
    exp_q.push_back(11'h091);
    pulse_start();
    @(negedge clk);
    check("t1_au_rst", au_rst, 1);
    check("t1_busy", busy, 1);
    check("t1_arst_au_en", au_en, 0);
    next_cycle();
    @(negedge clk);
    check("t1_fetch_au_rst", au_rst, 0);
    check("t1_fetch_au_en", au_en, 0);
    next_cycle();
    @(negedge clk);
    check("t1_apply_au_en", au_en, 1);
    check("t1_apply_au_u", au_u, 8'h00);
    next_cycle();
    done_seen = 0;
    wait_done(20, found);
    check("t1_done_seen", found, 1);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_count", count, 1);
    next_cycle();

    // two vectors, free-run
    push_word(8'h00);
    push_word(8'h02);
    exp_q.push_back(11'h091);
    exp_q.push_back(11'h57F);
    r0 = res_cnt;
    pulse_start();
    done_seen = 0;
    wait_done(30, found);
    check("t2_done_seen", found, 1);
    check("t2_results", res_cnt - r0, 2);
    check("t2_count", count, 2);

    // single-step mode; a step during ARST must not be remembered
    single = 1'b1;
    push_word(8'h00);
    push_word(8'h02);
    exp_q.push_back(11'h091);
    exp_q.push_back(11'h57F);
    pulse_start();
    pulse_step();
    en_seen = 0; done_seen = 0;
    run_cycles(10);
    check("t3_no_en_without_step", en_seen, 0);
    check("t3_hold_fetch", dbg_state, ST_FETCH);
    r0 = res_cnt; en_seen = 0;
    pulse_step();
    run_cycles(8);
    check("t3_step1_en", en_seen, 1);
    check("t3_step1_results", res_cnt - r0, 1);
    check("t3_step1_fetch", dbg_state, ST_FETCH);
    r0 = res_cnt; en_seen = 0; done_seen = 0;
    pulse_step();
    run_cycles(8);
    check("t3_step2_en", en_seen, 1);
    check("t3_step2_results", res_cnt - r0, 1);
    check("t3_done", done_seen, 1);
    check("t3_count", count, 2);
    single = 1'b0;

    // overflow: nine writes into an 8-deep FIFO while idle
    words[0] = 8'h00; words[1] = 8'h02; words[2] = 8'h13; words[3] = 8'h24;
    words[4] = 8'h35; words[5] = 8'h46; words[6] = 8'h57; words[7] = 8'h68;
    ms = 3'd0;
    for (int i = 0; i < 8; i++) begin
      push_word(words[i]);
      exp_q.push_back({ms, au_out(ms, words[i])});
      ms = au_next(ms, words[i]);
    end
    check("t4_err_ovf_before", err_ovf, 0);
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    @(negedge clk);
    check("t4_wr_ready_full", wr_ready, 0);
    next_cycle();
    wr_valid = 1'b0;
    check("t4_err_ovf", err_ovf, 1);
    r0 = res_cnt; en_seen = 0;
    pulse_start();
    wait_done(100, found);
    check("t4_done_seen", found, 1);
    check("t4_en_count", en_seen, 8);
    check("t4_results", res_cnt - r0, 8);
    check("t4_count", count, 8);
    check("t4_err_ovf_sticky", err_ovf, 1);

    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("rst_clears_err_ovf", err_ovf, 0);

    // back-pressure in WAIT_OUT
    push_word(8'h00);
    push_word(8'h02);
    exp_q.push_back(11'h091);
    exp_q.push_back(11'h57F);
    rd_ready = 1'b0;
    pulse_start();
    wait_rd_valid(20, found);
    check("t5_rd_valid_seen", found, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_rd_valid_hold", rd_valid, 1);
      check("t5_rd_data_stable", rd_data, 11'h091);
      check("t5_no_au_en", au_en, 0);
      next_cycle();
    end
    rd_ready = 1'b1;
    wait_done(30, found);
    check("t5_done_seen", found, 1);
    check("t5_count", count, 2);

    // reset while a result is pending with three vectors still queued
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    rd_ready = 1'b0;
    pulse_start();
    wait_rd_valid(20, found);
    check("t6_rd_valid_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rd_valid", rd_valid, 0);
    check("t6_rst_wr_ready", wr_ready, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t6_state_idle", dbg_state, ST_IDLE);
    check("t6_busy", busy, 0);
    check("t6_count", count, 0);
    check("t6_rd_data_cleared", rd_data, 0);
    next_cycle();
    rd_ready = 1'b1;
    en_seen = 0;
    pulse_start();
    wait_done(4, found);
    check("t6_immediate_done", found, 1);
    check("t6_no_au_en", en_seen, 0);
    check("t6_count_after", count, 0);

    run_cycles(2);
    check("exp_q_drained", 16'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass + sb_pass, n_total + sb_total);
    $finish;
  end

endmodule
